// File: rtl/spi_mem_responder_pkg.sv
// Shared constants, state encoding and command decode for the SPI memory responder.
package spi_mem_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         SPI_ADDR_BITS = 24;

    localparam int ST_W = 6;
    typedef logic [ST_W-1:0] state_t;

    // One-hot encoding, one bit per state.
    localparam state_t ST_IDLE    = 6'b000001;
    localparam state_t ST_CMD     = 6'b000010;
    localparam state_t ST_ADDR    = 6'b000100;
    localparam state_t ST_RD_DATA = 6'b001000;
    localparam state_t ST_WR_DATA = 6'b010000;
    localparam state_t ST_IGNORE  = 6'b100000;

    typedef enum logic [1:0] {
        CMD_KIND_READ,
        CMD_KIND_WRITE,
        CMD_KIND_BAD
    } cmd_kind_t;

    function automatic cmd_kind_t decode_cmd(input logic [7:0] cmd_byte);
        cmd_kind_t kind;
        case (cmd_byte)
            SPI_CMD_READ:  kind = CMD_KIND_READ;
            SPI_CMD_WRITE: kind = CMD_KIND_WRITE;
            default:       kind = CMD_KIND_BAD;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI pins, host preload port and status flags of the SPI memory responder.
interface spi_mem_responder_if #(
    parameter int ADDR_W = 6
);
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              miso;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              busy;
    logic              cmd_error;

    modport master (
        output sclk, mosi, cs_n, host_we, host_addr, host_wdata,
        input  miso, busy, cmd_error
    );

    modport slave (
        input  sclk, mosi, cs_n, host_we, host_addr, host_wdata,
        output miso, busy, cmd_error
    );
endinterface

// File: rtl/spi_mem_responder_sync_edge.sv
// Two-flop synchronizer plus one delay flop for rise/fall detection of a slow pin.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [2:0] pipe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= {3{RESET_VAL}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], din};
        end
    end

    assign sync = pipe_reg[1];
    assign rise = pipe_reg[1] & ~pipe_reg[2];
    assign fall = ~pipe_reg[1] & pipe_reg[2];
endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target serving a byte-addressed RAM with READ/WRITE commands and a host preload port.
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst_n,
    spi_mem_responder_if.slave bus
);
    localparam int SHW = (ADDR_W > 8) ? ADDR_W : 8;

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise_unused, cs_fall;
    logic [1:0] mosi_pipe_reg;
    logic mosi_sync;

    state_t state_reg, state_next;
    logic [4:0]        bit_cnt_reg;
    logic [SHW-2:0]    shift_reg;
    logic [SHW-1:0]    shift_in;
    logic [ADDR_W-1:0] addr_ptr_reg;
    logic [7:0]        tx_byte_reg;
    logic              load_pend_reg;
    logic              is_read_reg;
    logic              cmd_error_reg;
    logic              busy_reg;
    logic [1:0]        settle_cnt_reg;
    logic              settled, active;

    logic frame_start, shift_en, cmd_done, addr_done, byte_done, rd_fall, spi_we, miso_out;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram [DEPTH];
    logic [7:0]        ram_rd_reg;

    // cs_n idles high so a pin already low at reset release shows up as low, not as a fresh fall.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.sclk),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.cs_n),
        .sync(cs_sync), .rise(cs_rise_unused), .fall(cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_pipe_reg <= '0;
        end else begin
            mosi_pipe_reg <= {mosi_pipe_reg[0], bus.mosi};
        end
    end

    assign mosi_sync = mosi_pipe_reg[1];
    assign shift_in  = {shift_reg, mosi_sync};
    assign settled   = (settle_cnt_reg == 2'd3);
    assign active    = ~cs_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (settled) begin
                    if (cs_fall) begin
                        state_next = ST_CMD;
                    end else if (!cs_sync) begin
                        state_next = ST_IGNORE;
                    end
                end
            end
            ST_CMD: begin
                if (cmd_done) begin
                    state_next = (decode_cmd(shift_in[7:0]) == CMD_KIND_BAD) ? ST_IGNORE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (addr_done) begin
                    state_next = is_read_reg ? ST_RD_DATA : ST_WR_DATA;
                end
            end
            ST_RD_DATA, ST_WR_DATA, ST_IGNORE: ;
            default: state_next = ST_IDLE;
        endcase
        // Deselect wins over every other transition.
        if (state_reg != ST_IDLE && cs_sync) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        frame_start = 1'b0;
        shift_en    = 1'b0;
        cmd_done    = 1'b0;
        addr_done   = 1'b0;
        byte_done   = 1'b0;
        rd_fall     = 1'b0;
        spi_we      = 1'b0;
        miso_out    = 1'b0;
        case (state_reg)
            ST_IDLE: frame_start = settled & cs_fall;
            ST_CMD: begin
                shift_en = active & sclk_rise;
                cmd_done = active & sclk_rise & (bit_cnt_reg == 5'd7);
            end
            ST_ADDR: begin
                shift_en  = active & sclk_rise;
                addr_done = active & sclk_rise & (bit_cnt_reg == 5'(SPI_ADDR_BITS - 1));
            end
            ST_RD_DATA: begin
                shift_en  = active & sclk_rise;
                byte_done = active & sclk_rise & (bit_cnt_reg[2:0] == 3'd7);
                rd_fall   = active & sclk_fall;
                miso_out  = tx_byte_reg[7];
            end
            ST_WR_DATA: begin
                shift_en  = active & sclk_rise;
                byte_done = active & sclk_rise & (bit_cnt_reg[2:0] == 3'd7);
                spi_we    = active & sclk_rise & (bit_cnt_reg[2:0] == 3'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            addr_ptr_reg   <= '0;
            tx_byte_reg    <= '0;
            load_pend_reg  <= 1'b0;
            is_read_reg    <= 1'b0;
            cmd_error_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            settle_cnt_reg <= '0;
        end else begin
            busy_reg <= ~cs_sync;
            if (!settled) begin
                settle_cnt_reg <= settle_cnt_reg + 2'd1;
            end
            if (frame_start) begin
                cmd_error_reg <= 1'b0;
            end else if (cmd_done && decode_cmd(shift_in[7:0]) == CMD_KIND_BAD) begin
                cmd_error_reg <= 1'b1;
            end
            if (state_reg == ST_IDLE || cs_sync) begin
                bit_cnt_reg   <= '0;
                shift_reg     <= '0;
                tx_byte_reg   <= '0;
                load_pend_reg <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift_reg <= shift_in[SHW-2:0];
                end
                if (cmd_done || addr_done || byte_done) begin
                    bit_cnt_reg <= '0;
                end else if (shift_en) begin
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end
                if (cmd_done) begin
                    is_read_reg <= (decode_cmd(shift_in[7:0]) == CMD_KIND_READ);
                end
                // A pending load makes the next sclk fall present a fresh byte.
                if (addr_done) begin
                    addr_ptr_reg  <= shift_in[ADDR_W-1:0];
                    load_pend_reg <= 1'b1;
                end else if (byte_done) begin
                    addr_ptr_reg  <= addr_ptr_reg + ADDR_W'(1);
                    load_pend_reg <= 1'b1;
                end else if (rd_fall && load_pend_reg) begin
                    tx_byte_reg   <= ram_rd_reg;
                    load_pend_reg <= 1'b0;
                end else if (rd_fall) begin
                    tx_byte_reg <= {tx_byte_reg[6:0], 1'b0};
                end
            end
        end
    end

    // Host writes only get through while no frame is in progress.
    assign ram_we    = spi_we | (bus.host_we & ~busy_reg);
    assign ram_waddr = spi_we ? addr_ptr_reg : bus.host_addr;
    assign ram_wdata = spi_we ? shift_in[7:0] : bus.host_wdata;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rd_reg <= ram[addr_ptr_reg];
    end

    assign bus.miso      = miso_out;
    assign bus.busy      = busy_reg;
    assign bus.cmd_error = cmd_error_reg;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench: table of SPI frames with expected read bytes and error flag, plus corner-case sequences.
module tb_spi_mem_responder;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int HALF   = 8;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    spi_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = tx[i];
            clks(HALF);
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            clks(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] dummy;
        spi_bits(cmd, 8, dummy);
        spi_bits(addr[23:16], 8, dummy);
        spi_bits(addr[15:8], 8, dummy);
        spi_bits(addr[7:0], 8, dummy);
    endtask

    task automatic frame_begin();
        bus.cs_n = 1'b0;
        clks(6);
    endtask

    task automatic frame_end();
        clks(4);
        bus.cs_n = 1'b1;
        clks(8);
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.host_we    = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = d;
        clks(1);
        bus.host_we = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [7:0] rx0, rx1;
        frame_begin();
        send_hdr(v.cmd, v.addr);
        spi_bits(v.d0, 8, rx0);
        spi_bits(v.d1, 8, rx1);
        frame_end();
        $display("%s: cmd %h addr %h tx %h %h rx %h %h err %b", tag, v.cmd, v.addr, v.d0, v.d1,
                 rx0, rx1, bus.cmd_error);
        check({tag, " byte0"}, rx0, v.e0);
        check({tag, " byte1"}, rx1, v.e1);
        check({tag, " cmd_error"}, {7'd0, bus.cmd_error}, {7'd0, v.e_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        vec_t v;

        vecs[0]  = '{8'h03, 24'h000005, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0};
        vecs[1]  = '{8'h02, 24'h000010, 8'hDE, 8'hAD, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h03, 24'h000010, 8'h00, 8'h00, 8'hDE, 8'hAD, 1'b0};
        vecs[3]  = '{8'h03, 24'hFFFF3F, 8'h00, 8'h00, 8'h81, 8'h7E, 1'b0};
        vecs[4]  = '{8'h02, 24'h000020, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'h03, 24'h000060, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0};
        vecs[6]  = '{8'h9F, 24'h000000, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{8'h03, 24'h000005, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0};
        vecs[8]  = '{8'h02, 24'h00003F, 8'h99, 8'h66, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h03, 24'h00003F, 8'h00, 8'h00, 8'h99, 8'h66, 1'b0};
        vecs[10] = '{8'h03, 24'h000000, 8'h00, 8'h00, 8'h66, 8'h55, 1'b0};

        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = '0;

        clks(3);
        $display("reset: miso %b busy %b cmd_error %b", bus.miso, bus.busy, bus.cmd_error);
        check("reset miso", {7'd0, bus.miso}, 8'h00);
        check("reset busy", {7'd0, bus.busy}, 8'h00);
        check("reset cmd_error", {7'd0, bus.cmd_error}, 8'h00);
        rst_n = 1'b1;
        clks(6);
        check("idle busy", {7'd0, bus.busy}, 8'h00);

        host_write(6'd5, 8'hA5);
        host_write(6'd6, 8'h3C);
        host_write(6'd63, 8'h81);
        host_write(6'd0, 8'h7E);
        host_write(6'd1, 8'h55);
        host_write(6'd2, 8'h33);
        host_write(6'd3, 8'h44);

        for (int i = 0; i < 11; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort a write after 5 bits: no RAM update, responder back to idle.
        frame_begin();
        send_hdr(8'h02, 24'h000002);
        spi_bits(8'hFF, 5, rx);
        bus.cs_n = 1'b1;
        clks(8);
        $display("abort: busy %b miso %b", bus.busy, bus.miso);
        check("abort busy", {7'd0, bus.busy}, 8'h00);
        check("abort miso", {7'd0, bus.miso}, 8'h00);
        v = '{8'h03, 24'h000002, 8'h00, 8'h00, 8'h33, 8'h44, 1'b0};
        run_vec("abort readback", v);

        // Bad command with a host write attempted mid-frame.
        frame_begin();
        spi_bits(8'h9F, 8, rx);
        clks(6);
        check("bad cmd_error mid", {7'd0, bus.cmd_error}, 8'h01);
        host_write(6'd1, 8'hEE);
        spi_bits(8'hA5, 8, rx);
        check("bad miso byte0", rx, 8'h00);
        spi_bits(8'h5A, 8, rx);
        check("bad miso byte1", rx, 8'h00);
        frame_end();
        $display("bad cmd: cmd_error %b after deselect", bus.cmd_error);
        check("bad cmd_error sticky", {7'd0, bus.cmd_error}, 8'h01);
        bus.cs_n = 1'b0;
        clks(6);
        check("cmd_error cleared", {7'd0, bus.cmd_error}, 8'h00);
        send_hdr(8'h03, 24'h000001);
        spi_bits(8'h00, 8, rx);
        frame_end();
        $display("host block: RAM[1] read %h", rx);
        check("host blocked RAM1", rx, 8'h55);

        // Reset in the middle of a read, then release with cs_n still low.
        frame_begin();
        send_hdr(8'h03, 24'h000005);
        spi_bits(8'h00, 2, rx);
        clks(6);
        check("pre-reset miso", {7'd0, bus.miso}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid-read reset: miso %b busy %b cmd_error %b", bus.miso, bus.busy, bus.cmd_error);
        check("async reset miso", {7'd0, bus.miso}, 8'h00);
        check("async reset busy", {7'd0, bus.busy}, 8'h00);
        check("async reset cmd_error", {7'd0, bus.cmd_error}, 8'h00);
        clks(3);
        rst_n = 1'b1;
        clks(8);
        send_hdr(8'h03, 24'h000005);
        spi_bits(8'h00, 8, rx);
        check("post-reset ignore byte0", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        check("post-reset ignore byte1", rx, 8'h00);
        bus.cs_n = 1'b1;
        clks(8);
        v = '{8'h03, 24'h000005, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0};
        run_vec("post-reset read", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
